// File: rtl/draw_fsm_circle_pipe.sv
// -----------------------------------------------------------------------------
// draw_fsm_circle_pipe
//
// Pipelined circle painter for an 800x525 VGA scan. For every scan position it
// produces the framebuffer address (v*800 + h) and a pixel colour. The colour
// is either a filled disc or a ring of THICK pixels. The ring's outer edge is
// the radius.
//
// Centre, radius, mode and colour arrive over a valid/ready handshake into a
// one-entry pending slot. The slot is promoted to the active set only when
// scan position (0,0) enters the pipeline, so a frame is never torn.
//
// Pipeline (3 clocks, addr and data_out aligned):
//   S1: offsets from centre, address, visible-window flag, radius squares
//   S2: squared distance
//   S3: hit test and colour select
//
// Ports:
//   clk                         pixel clock
//   rst_n                       synchronous active-low reset
//   horizontal_actual_position  H count 0..799
//   vertical_actual_position    V count 0..524
//   cfg_valid / cfg_ready       configuration handshake (ready = pending slot empty)
//   cfg_x, cfg_y, cfg_radius, cfg_mode, cfg_color   offered configuration
//   cfg_applied                 one-cycle pulse when pending becomes active
//   addr                        v*800 + h of the pixel on data_out
//   data_out                    pixel colour
//
// Optional build macro: CIRCLE_BLINK_EN. When it is defined, the circle blinks.
// Each hidden or shown phase lasts BLINK_FRAMES frame starts.
// -----------------------------------------------------------------------------
module draw_fsm_circle_pipe #(
    parameter int                 COLOR_W      = 12,
    parameter int                 X0_INIT      = 464,
    parameter int                 Y0_INIT      = 275,
    parameter int                 R_INIT       = 10,
    parameter int                 THICK        = 2,
    parameter logic [COLOR_W-1:0] COLOR_INIT   = 12'hF00,
    parameter logic [COLOR_W-1:0] BG_COLOR     = 12'h000,
    parameter int                 BLINK_FRAMES = 30
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [15:0]        horizontal_actual_position,
    input  logic [15:0]        vertical_actual_position,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [15:0]        cfg_x,
    input  logic [15:0]        cfg_y,
    input  logic [9:0]         cfg_radius,
    input  logic               cfg_mode,
    input  logic [COLOR_W-1:0] cfg_color,
    output logic               cfg_applied,
    output logic [18:0]        addr,
    output logic [COLOR_W-1:0] data_out
);

    localparam logic [9:0] THICK_L = 10'(THICK);

    // Active and pending configuration sets
    logic [15:0]        act_x_q, act_x_d, act_y_q, act_y_d;
    logic [9:0]         act_r_q, act_r_d;
    logic               act_mode_q, act_mode_d;
    logic [COLOR_W-1:0] act_color_q, act_color_d;
    logic               pend_full_q, pend_full_d;
    logic [15:0]        pend_x_q, pend_x_d, pend_y_q, pend_y_d;
    logic [9:0]         pend_r_q, pend_r_d;
    logic               pend_mode_q, pend_mode_d;
    logic [COLOR_W-1:0] pend_color_q, pend_color_d;
    logic               applied_q, applied_d;

    // Stage 1
    logic signed [16:0] s1_dx_q, s1_dx_d, s1_dy_q, s1_dy_d;
    logic [18:0]        s1_addr_q, s1_addr_d;
    logic               s1_vis_q, s1_vis_d;
    logic [19:0]        s1_rr_q, s1_rr_d, s1_ri_q, s1_ri_d;
    logic               s1_ring_q, s1_ring_d;
    logic [COLOR_W-1:0] s1_color_q, s1_color_d;

    // Stage 2
    logic [34:0]        s2_sq_q, s2_sq_d;
    logic [18:0]        s2_addr_q, s2_addr_d;
    logic               s2_vis_q, s2_vis_d;
    logic [19:0]        s2_rr_q, s2_rr_d, s2_ri_q, s2_ri_d;
    logic               s2_ring_q, s2_ring_d;
    logic [COLOR_W-1:0] s2_color_q, s2_color_d;

    // Stage 3 (outputs)
    logic [18:0]        addr_q, addr_d;
    logic [COLOR_W-1:0] data_q, data_d;

    logic               frame_start, cfg_fire, apply, blink_vis, in_window, hit;
    logic [9:0]         r_inner;
    logic signed [33:0] dx_ext, dy_ext, dx_sq, dy_sq;

    assign frame_start = (horizontal_actual_position == 16'd0) &&
                         (vertical_actual_position == 16'd0);
    assign cfg_fire    = cfg_valid && !pend_full_q;
    // A fire and an apply never coincide: fire needs an empty slot, apply a full one.
    assign apply       = frame_start && pend_full_q;

    assign in_window = (horizontal_actual_position >= 16'd144) &&
                       (horizontal_actual_position <= 16'd783) &&
                       (vertical_actual_position   >= 16'd35)  &&
                       (vertical_actual_position   <= 16'd514);

    assign r_inner = act_r_q - THICK_L;   // only consumed when the ring is non-degenerate
    assign dx_ext  = 34'(s1_dx_q);
    assign dy_ext  = 34'(s1_dy_q);
    assign dx_sq   = dx_ext * dx_ext;
    assign dy_sq   = dy_ext * dy_ext;
    assign hit     = (s2_sq_q <= 35'(s2_rr_q)) && (!s2_ring_q || (s2_sq_q > 35'(s2_ri_q)));

`ifdef CIRCLE_BLINK_EN
    localparam int             BCW        = (BLINK_FRAMES < 2) ? 1 : $clog2(BLINK_FRAMES);
    localparam logic [BCW-1:0] BLINK_LAST = BCW'(BLINK_FRAMES - 1);
    logic [BCW-1:0] blink_cnt_q, blink_cnt_d;
    logic           blink_vis_q, blink_vis_d;
    assign blink_vis = blink_vis_q;

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_vis_d = blink_vis_q;
        if (apply) begin
            // A freshly applied configuration is always shown at once
            blink_cnt_d = '0;
            blink_vis_d = 1'b1;
        end else if (frame_start) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                blink_vis_d = !blink_vis_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blink_cnt_q <= '0;
            blink_vis_q <= 1'b1;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_vis_q <= blink_vis_d;
        end
    end
`else
    // Blinking is not built in, so the circle is always shown.
    // BLINK_FRAMES is referenced only so that it stays a live parameter.
    assign blink_vis = (BLINK_FRAMES >= 0) || 1'b1;
`endif

    always_comb begin
        act_x_d      = act_x_q;
        act_y_d      = act_y_q;
        act_r_d      = act_r_q;
        act_mode_d   = act_mode_q;
        act_color_d  = act_color_q;
        pend_full_d  = pend_full_q;
        pend_x_d     = pend_x_q;
        pend_y_d     = pend_y_q;
        pend_r_d     = pend_r_q;
        pend_mode_d  = pend_mode_q;
        pend_color_d = pend_color_q;
        applied_d    = apply;

        if (apply) begin
            act_x_d     = pend_x_q;
            act_y_d     = pend_y_q;
            act_r_d     = pend_r_q;
            act_mode_d  = pend_mode_q;
            act_color_d = pend_color_q;
            pend_full_d = 1'b0;
        end else if (cfg_fire) begin
            pend_x_d     = cfg_x;
            pend_y_d     = cfg_y;
            pend_r_d     = cfg_radius;
            pend_mode_d  = cfg_mode;
            pend_color_d = cfg_color;
            pend_full_d  = 1'b1;
        end

        // S1 uses the active set as registered. The pixel at (0,0) therefore
        // still sees the old set, and the new set starts with the next pixel.
        s1_dx_d    = $signed({1'b0, horizontal_actual_position}) - $signed({1'b0, act_x_q});
        s1_dy_d    = $signed({1'b0, vertical_actual_position})   - $signed({1'b0, act_y_q});
        s1_addr_d  = 19'(vertical_actual_position) * 19'd800 + 19'(horizontal_actual_position);
        s1_vis_d   = in_window && blink_vis;
        s1_rr_d    = 20'(act_r_q) * 20'(act_r_q);
        // A ring at least as thick as the radius is simply the filled disc
        s1_ring_d  = act_mode_q && (act_r_q > THICK_L);
        s1_ri_d    = 20'(r_inner) * 20'(r_inner);
        s1_color_d = act_color_q;

        s2_sq_d    = 35'($unsigned(dx_sq)) + 35'($unsigned(dy_sq));
        s2_addr_d  = s1_addr_q;
        s2_vis_d   = s1_vis_q;
        s2_rr_d    = s1_rr_q;
        s2_ri_d    = s1_ri_q;
        s2_ring_d  = s1_ring_q;
        s2_color_d = s1_color_q;

        addr_d = s2_addr_q;
        data_d = (s2_vis_q && hit) ? s2_color_q : BG_COLOR;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            act_x_q      <= 16'(X0_INIT);
            act_y_q      <= 16'(Y0_INIT);
            act_r_q      <= 10'(R_INIT);
            act_mode_q   <= 1'b0;
            act_color_q  <= COLOR_INIT;
            pend_full_q  <= 1'b0;
            pend_x_q     <= '0;
            pend_y_q     <= '0;
            pend_r_q     <= '0;
            pend_mode_q  <= 1'b0;
            pend_color_q <= '0;
            applied_q    <= 1'b0;
            s1_dx_q      <= '0;
            s1_dy_q      <= '0;
            s1_addr_q    <= '0;
            s1_vis_q     <= 1'b0;
            s1_rr_q      <= '0;
            s1_ri_q      <= '0;
            s1_ring_q    <= 1'b0;
            s1_color_q   <= BG_COLOR;
            s2_sq_q      <= '0;
            s2_addr_q    <= '0;
            s2_vis_q     <= 1'b0;
            s2_rr_q      <= '0;
            s2_ri_q      <= '0;
            s2_ring_q    <= 1'b0;
            s2_color_q   <= BG_COLOR;
            addr_q       <= '0;
            data_q       <= BG_COLOR;
        end else begin
            act_x_q      <= act_x_d;
            act_y_q      <= act_y_d;
            act_r_q      <= act_r_d;
            act_mode_q   <= act_mode_d;
            act_color_q  <= act_color_d;
            pend_full_q  <= pend_full_d;
            pend_x_q     <= pend_x_d;
            pend_y_q     <= pend_y_d;
            pend_r_q     <= pend_r_d;
            pend_mode_q  <= pend_mode_d;
            pend_color_q <= pend_color_d;
            applied_q    <= applied_d;
            s1_dx_q      <= s1_dx_d;
            s1_dy_q      <= s1_dy_d;
            s1_addr_q    <= s1_addr_d;
            s1_vis_q     <= s1_vis_d;
            s1_rr_q      <= s1_rr_d;
            s1_ri_q      <= s1_ri_d;
            s1_ring_q    <= s1_ring_d;
            s1_color_q   <= s1_color_d;
            s2_sq_q      <= s2_sq_d;
            s2_addr_q    <= s2_addr_d;
            s2_vis_q     <= s2_vis_d;
            s2_rr_q      <= s2_rr_d;
            s2_ri_q      <= s2_ri_d;
            s2_ring_q    <= s2_ring_d;
            s2_color_q   <= s2_color_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
        end
    end

    assign cfg_ready   = !pend_full_q;
    assign cfg_applied = applied_q;
    assign addr        = addr_q;
    assign data_out    = data_q;

endmodule

// File: tb/tb_draw_fsm_circle_pipe.sv
// -----------------------------------------------------------------------------
// Testbench for draw_fsm_circle_pipe in its default build (no blinking).
//
// The bench drives one scan position per clock. It keeps a behavioural model
// of the circle: an active set, a one-entry pending set and distance-squared
// hit rules. Each expected pixel is queued and compared with the DUT output
// three clocks later. cfg_ready and cfg_applied are checked every cycle.
// -----------------------------------------------------------------------------
module tb_draw_fsm_circle_pipe;

    localparam int          THICK = 2;
    localparam logic [11:0] BG    = 12'h000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] hpos, vpos;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] cfg_x, cfg_y;
    logic [9:0]  cfg_radius;
    logic        cfg_mode;
    logic [11:0] cfg_color;
    logic        cfg_applied;
    logic [18:0] addr;
    logic [11:0] data_out;

    always #5 clk = ~clk;

    draw_fsm_circle_pipe dut (
        .clk                        (clk),
        .rst_n                      (rst_n),
        .horizontal_actual_position (hpos),
        .vertical_actual_position   (vpos),
        .cfg_valid                  (cfg_valid),
        .cfg_ready                  (cfg_ready),
        .cfg_x                      (cfg_x),
        .cfg_y                      (cfg_y),
        .cfg_radius                 (cfg_radius),
        .cfg_mode                   (cfg_mode),
        .cfg_color                  (cfg_color),
        .cfg_applied                (cfg_applied),
        .addr                       (addr),
        .data_out                   (data_out)
    );

    typedef struct {
        int          x;
        int          y;
        int          r;
        bit          mode;
        logic [11:0] color;
    } cfg_t;

    typedef struct {
        logic [18:0] addr;
        logic [11:0] color;
        int          h;
        int          v;
    } exp_t;

    cfg_t m_act, m_pend, none;
    bit   m_pend_full;
    exp_t expq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic cfg_t mk(int x, int y, int r, bit mode, logic [11:0] color);
        cfg_t c;
        c.x = x; c.y = y; c.r = r; c.mode = mode; c.color = color;
        return c;
    endfunction

    // Expected colour from geometry: inside radius, outside inner ring radius
    function automatic logic [11:0] model_pix(int h, int v, cfg_t c);
        longint dx, dy, sq, inner;
        if (h < 144 || h > 783 || v < 35 || v > 514) return BG;
        dx = h - c.x;
        dy = v - c.y;
        sq = dx * dx + dy * dy;
        if (sq > longint'(c.r) * c.r) return BG;
        if (c.mode && c.r > THICK) begin
            inner = c.r - THICK;
            if (sq <= inner * inner) return BG;
        end
        return c.color;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_act       = mk(464, 275, 10, 1'b0, 12'hF00);
        m_pend_full = 1'b0;
        expq.delete();
    endtask

    // One scan position per clock, with an optional configuration offer
    task automatic step(int h, int v, bit vld, cfg_t c);
        exp_t e;
        bit   fs, app;
        hpos       = 16'(h);
        vpos       = 16'(v);
        cfg_valid  = vld;
        cfg_x      = 16'(c.x);
        cfg_y      = 16'(c.y);
        cfg_radius = 10'(c.r);
        cfg_mode   = c.mode;
        cfg_color  = c.color;
        check("cfg_ready", 32'(cfg_ready), 32'(!m_pend_full));
        e.addr  = 19'(v * 800 + h);
        e.color = model_pix(h, v, m_act);
        e.h     = h;
        e.v     = v;
        expq.push_back(e);
        fs  = (h == 0 && v == 0);
        app = fs && m_pend_full;
        if (app) begin
            m_act       = m_pend;
            m_pend_full = 1'b0;
        end else if (vld && !m_pend_full) begin
            m_pend      = c;
            m_pend_full = 1'b1;
        end
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        check("cfg_applied", 32'(cfg_applied), 32'(app));
        if (expq.size() == 3) begin
            e = expq.pop_front();
            check($sformatf("addr(%0d,%0d)", e.h, e.v), 32'(addr), 32'(e.addr));
            check($sformatf("data(%0d,%0d)", e.h, e.v), 32'(data_out), 32'(e.color));
        end
    endtask

    task automatic pix(int h, int v);
        step(h, v, 1'b0, none);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_data", 32'(data_out), 32'(BG));
        check("rst_applied", 32'(cfg_applied), 32'd0);
        check("rst_ready", 32'(cfg_ready), 32'd1);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int h, v;
        none      = mk(0, 0, 0, 1'b0, 12'h000);
        rst_n     = 1'b0;
        hpos      = '0;
        vpos      = '0;
        cfg_valid = 1'b0;
        cfg_x     = '0;
        cfg_y     = '0;
        cfg_radius = '0;
        cfg_mode  = 1'b0;
        cfg_color = '0;
        @(posedge clk);
        #1;
        do_reset();

        // Reset defaults: centre hit, just outside the radius missed
        pix(464, 275);
        pix(475, 275);
        pix(474, 275);
        pix(467, 275);
        pix(464, 285);
        pix(0, 1);
        pix(0, 1);

        // Mid-frame offer: ring R=10 at the default centre, applied at next (0,0)
        step(300, 200, 1'b1, mk(464, 275, 10, 1'b1, 12'h0F0));
        pix(467, 275);
        pix(473, 275);
        step(470, 280, 1'b1, mk(300, 300, 5, 1'b0, 12'hFFF));
        pix(0, 0);
        pix(473, 275);
        pix(467, 275);
        pix(475, 275);
        pix(464, 265);
        pix(464, 267);

        // Centre near the left border: points within the radius but left of H=144 stay background
        step(10, 10, 1'b1, mk(105, 275, 10, 1'b0, 12'h00F));
        pix(0, 0);
        pix(100, 275);
        pix(105, 275);
        pix(144, 275);

        // Offer on the frame-start cycle is applied one frame later
        step(0, 0, 1'b1, mk(300, 275, 3, 1'b0, 12'hABC));
        pix(105, 275);
        pix(300, 275);
        pix(0, 0);
        pix(300, 275);
        pix(302, 277);
        pix(303, 275);

        // Radius 0 hits only the centre; a ring no wider than THICK is a filled disc
        step(5, 5, 1'b1, mk(400, 100, 0, 1'b1, 12'h123));
        pix(0, 0);
        pix(400, 100);
        pix(401, 100);
        step(5, 5, 1'b1, mk(400, 100, 2, 1'b1, 12'h456));
        pix(0, 0);
        pix(400, 100);
        pix(401, 101);
        pix(402, 100);
        pix(403, 100);

        // Randomized scan and configuration traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                h = 0; v = 0;
            end else if ($urandom_range(0, 1) == 0) begin
                h = m_act.x + int'($urandom_range(0, 60)) - 30;
                v = m_act.y + int'($urandom_range(0, 60)) - 30;
                if (h < 0) h = 0;
                if (h > 799) h = 799;
                if (v < 0) v = 0;
                if (v > 524) v = 524;
            end else begin
                h = int'($urandom_range(0, 799));
                v = int'($urandom_range(0, 524));
            end
            if ($urandom_range(0, 14) == 0)
                step(h, v, 1'b1, mk(int'($urandom_range(150, 780)), int'($urandom_range(40, 510)),
                                    int'($urandom_range(0, 40)), 1'($urandom_range(0, 1)),
                                    12'($urandom_range(1, 4095))));
            else
                pix(h, v);
        end

        // Reset mid-frame with a pending offer and hits in flight
        step(200, 200, 1'b1, mk(250, 250, 20, 1'b0, 12'hEEE));
        pix(250, 250);
        pix(m_act.x, m_act.y);
        do_reset();
        pix(0, 0);
        pix(464, 275);
        pix(250, 250);
        pix(473, 275);
        pix(0, 1);
        pix(0, 1);
        pix(0, 1);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
